// File: rtl/mem_responder.sv
// Word-addressed RAM slave for the memEN/RW/MFC bus: programmable wait states,
// four-phase completion handshake, and out-of-range address flagging.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              MFC,
    output logic              addr_err
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_CYCLES must be in 1..15");
    end
    if (DEPTH < 1 || DEPTH > (64'd1 << ADDR_W)) begin : g_bad_depth
        $error("mem_responder: DEPTH must be in 1..2**ADDR_W");
    end

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_C = WAIT_CYCLES[3:0];
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic               in_range;
    logic               access;
    logic               wr_en;

    always_comb begin
        idx      = addr[IDX_W-1:0];
        in_range = ({1'b0, addr} < DEPTH_C);
        access   = (state_q == StBusy) && memEN && (cnt_q == 4'd1);
        // Gate with rst so an aborted request can never commit its write.
        wr_en    = !rst && access && !RW && in_range;
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            MFC      <= 1'b0;
            data_out <= '0;
            addr_err <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (memEN) begin
                        state_q <= StBusy;
                        cnt_q   <= WAIT_C;
                    end
                end
                StBusy: begin
                    if (!memEN) begin
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd1) begin
                        state_q  <= StAck;
                        cnt_q    <= 4'd0;
                        MFC      <= 1'b1;
                        addr_err <= !in_range;
                        if (RW) begin
                            data_out <= in_range ? mem[idx] : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAck: begin
                    if (!memEN) begin
                        state_q  <= StIdle;
                        MFC      <= 1'b0;
                        addr_err <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of bus requests plus hand-written
// abort, held-memEN and mid-request reset sequences.
module tb_mem_responder;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned DEPTH       = 200;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int          EXP_CYC     = WAIT_CYCLES + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              memEN;
    logic              RW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              MFC;
    logic              addr_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memEN   (memEN),
        .RW      (RW),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .MFC     (MFC),
        .addr_err(addr_err)
    );

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_do;
        logic              exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called just after a rising edge. The first memEN cycle carries inverted
    // RW/addr/data, which the responder must not sample.
    task automatic req_start(input logic rw, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, output int cyc);
        cyc     = 0;
        memEN   = 1'b1;
        RW      = ~rw;
        addr    = ~a;
        data_in = ~d;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            RW      = rw;
            addr    = a;
            data_in = d;
            if (MFC) break;
        end
    endtask

    task automatic req_end(input logic [DATA_W-1:0] exp_do);
        memEN = 1'b0;
        @(posedge clk);
        #1;
        chk("mfc_fall", {31'd0, MFC}, 32'd0);
        chk("err_fall", {31'd0, addr_err}, 32'd0);
        chk("dout_retain", {16'd0, data_out}, {16'd0, exp_do});
    endtask

    task automatic req(input string name, input logic rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_do,
                       input logic exp_err);
        int cyc;
        req_start(rw, a, d, cyc);
        chk({name, "_lat"}, cyc, EXP_CYC);
        chk({name, "_dout"}, {16'd0, data_out}, {16'd0, exp_do});
        chk({name, "_err"}, {31'd0, addr_err}, {31'd0, exp_err});
        req_end(exp_do);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bad;

        vecs[0]  = '{1'b0, 8'h05, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 8'h10, 16'h1234, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 8'h11, 16'h5555, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 8'h20, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 8'hC7, 16'h7777, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 8'h05, 16'h0000, 16'hBEEF, 1'b0};
        vecs[6]  = '{1'b1, 8'hF0, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 8'h10, 16'h0000, 16'h1234, 1'b0};
        vecs[8]  = '{1'b0, 8'hF0, 16'hAAAA, 16'h1234, 1'b1};
        vecs[9]  = '{1'b1, 8'hC7, 16'h0000, 16'h7777, 1'b0};
        vecs[10] = '{1'b1, 8'hC8, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{1'b1, 8'h11, 16'h0000, 16'h5555, 1'b0};
        vecs[12] = '{1'b1, 8'h10, 16'h0000, 16'h1234, 1'b0};

        rst     = 1'b1;
        memEN   = 1'b0;
        RW      = 1'b0;
        addr    = '0;
        data_in = '0;
        #12;
        chk("rst_mfc", {31'd0, MFC}, 32'd0);
        chk("rst_dout", {16'd0, data_out}, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].a, vecs[i].d,
                vecs[i].exp_do, vecs[i].exp_err);
        end

        // Abort: memEN drops just before the access edge of a write.
        memEN   = 1'b1;
        RW      = 1'b0;
        addr    = 8'h20;
        data_in = 16'hFFFF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        memEN = 1'b0;
        bad   = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (MFC) bad++;
        end
        chk("abort_mfc", bad, 0);
        chk("abort_dout", {16'd0, data_out}, 32'h1234);
        req("abort_rd", 1'b1, 8'h20, 16'h0000, 16'h0000, 1'b0);

        // Held memEN in ACK while RW/addr/data_in wander: no second access.
        req_start(1'b1, 8'h05, 16'h0000, cyc);
        chk("held_lat", cyc, EXP_CYC);
        chk("held_dout0", {16'd0, data_out}, 32'hBEEF);
        for (int i = 0; i < 10; i++) begin
            RW      = 1'b0;
            addr    = i[0] ? 8'h10 : 8'h05;
            data_in = 16'hDEA0 + 16'(i);
            @(posedge clk);
            #1;
            chk($sformatf("held_mfc%0d", i), {31'd0, MFC}, 32'd1);
            chk($sformatf("held_dout%0d", i), {16'd0, data_out}, 32'hBEEF);
        end
        req_end(16'hBEEF);
        req("held_rd05", 1'b1, 8'h05, 16'h0000, 16'hBEEF, 1'b0);
        req("held_rd10", 1'b1, 8'h10, 16'h0000, 16'h1234, 1'b0);

        // Asynchronous reset during a write's wait state.
        memEN   = 1'b1;
        RW      = 1'b0;
        addr    = 8'h11;
        data_in = 16'h9999;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2 rst = 1'b1;
        #1;
        chk("arst_mfc", {31'd0, MFC}, 32'd0);
        chk("arst_dout", {16'd0, data_out}, 32'd0);
        chk("arst_err", {31'd0, addr_err}, 32'd0);
        @(posedge clk);
        #1;
        memEN = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        req("arst_rd11", 1'b1, 8'h11, 16'h0000, 16'h5555, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
